// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: area-reduced AES SubBytes stage feeding ShiftRows.
// Substitutes LANES bytes per clock through shared S-box logic.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake, ready only in IDLE
//   w0_in..w3_in         state columns, s0 in w0_in[31:24]
//   out_valid/out_ready  output handshake, valid only in DONE
//   w0_out..w3_out       registered substituted columns
//   inv                  (SUB_BYTES_INV_SBOX_EN only) 1 = inverse S-box
//
// Parameter LANES: 4, 8 or 16 bytes per cycle (NCHUNK = 16/LANES).
// Macro SUB_BYTES_INV_SBOX_EN adds the inv port and the inverse S-box.

module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SUB_BYTES_INV_SBOX_EN
    input  logic        inv,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] w0_in,
    input  logic [31:0] w1_in,
    input  logic [31:0] w2_in,
    input  logic [31:0] w3_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] w0_out,
    output logic [31:0] w1_out,
    output logic [31:0] w2_out,
    output logic [31:0] w3_out
);

    localparam int NCHUNK = 16 / LANES;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (!(LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
            $error("sub_bytes_seq: LANES must be 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [127:0]   work;
    logic [127:0]   next_work;
    logic [127:0]   dout;
    logic           dec;
    int             base;

    // GF(2^8) arithmetic, AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 = x^-1 for x != 0, and 0 maps to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x,
                                        input logic       d);
        logic [7:0] b;
        logic [7:0] t;
        if (d) begin
            t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^
                {x[1:0], x[7:2]} ^ 8'h05;
            b = gf_inv(t);
        end else begin
            t = gf_inv(x);
            b = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^
                {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
        end
        return b;
    endfunction

`ifdef SUB_BYTES_INV_SBOX_EN
    logic inv_q;
    assign dec = inv_q;
`else
    assign dec = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    // Substitute the current chunk in place; byte k sits at
    // work[127-8k -: 8], so s0 is the MSB of w0.
    always_comb begin
        next_work = work;
        base = 0;
        for (int l = 0; l < LANES; l++) begin
            base = 127 - 8 * (int'(cnt) * LANES + l);
            next_work[base -: 8] = sbox(work[base -: 8], dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
`ifdef SUB_BYTES_INV_SBOX_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= {w0_in, w1_in, w2_in, w3_in};
                        cnt   <= '0;
                        state <= BUSY;
`ifdef SUB_BYTES_INV_SBOX_EN
                        inv_q <= inv;
`endif
                    end
                end
                BUSY: begin
                    work <= next_work;
                    if (cnt == LAST) begin
                        // Output register only loads complete blocks
                        dout      <= next_work;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign w0_out = dout[127:96];
    assign w1_out = dout[95:64];
    assign w2_out = dout[63:32];
    assign w3_out = dout[31:0];

endmodule
